// File: rtl/equal_pkg.sv
// equal_pkg: shared FSM states, default width and index-width helper for the serial comparators
package equal_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEFAULT_WIDTH = 6;
  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/bit_counter_mod.sv
// bit_counter_mod: modulo-MOD up-counter with clear, enable and terminal-count flag
module bit_counter_mod
  import equal_pkg::*;
#(
  parameter int MOD = DEFAULT_WIDTH,
  parameter int W   = idx_w(DEFAULT_WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(MOD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/serial_equal_6.sv
// serial_equal_6: bit-serial LSB-first equality checker reporting equality and lowest differing bit
module serial_equal_6
  import equal_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             equ,
  output logic [IDX_W-1:0] first_diff
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt, acc, acc_nxt;
  logic tc, diff, diff_nxt, x, accept, launch;
  assign launch    = state == IDLE && start;
  assign bit_ready = state == SHIFT;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign accept    = bit_valid & bit_ready;
  assign x         = a_bit ^ b_bit;
  assign diff_nxt  = diff | x;
  assign acc_nxt   = (x && !diff) ? cnt : acc;
  bit_counter_mod #(.MOD(WIDTH), .W(IDX_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch), .en(accept), .cnt(cnt), .tc(tc)
  );
  always_comb
    state_nxt = launch ? SHIFT :
                (state == SHIFT && accept && tc) ? DONE :
                (state == DONE) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      diff       <= 1'b0;
      acc        <= '0;
      equ        <= 1'b0;
      first_diff <= '0;
    end else begin
      if (launch) begin
        diff <= 1'b0;
        acc  <= '0;
      end else if (accept) begin
        diff <= diff_nxt;
        acc  <= acc_nxt;
      end
      if (accept && tc) begin
        equ        <= !diff_nxt;
        first_diff <= diff_nxt ? acc_nxt : '0;
      end
    end
endmodule

// File: tb/tb_serial_equal_6.sv
// tb_serial_equal_6: randomized and directed checks of serial_equal_6 against a word-level model
module tb_serial_equal_6;
  localparam int W = 6;
  localparam int IW = $clog2(W);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic bit_ready, busy, done, equ;
  logic [IW-1:0] first_diff;
  int tests = 0, fails = 0;
  logic chk = 1'b0;
  int phase = 0, k = 0, m_fd = 0;
  logic [W-1:0] a_w = '0, b_w = '0;
  logic m_equ = 1'b0;

  serial_equal_6 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .a_bit(a_bit),
    .b_bit(b_bit), .bit_ready(bit_ready), .busy(busy), .done(done), .equ(equ),
    .first_diff(first_diff)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a ^ b;
    for (int i = 0; i < W; i++) if (d[i]) return i;
    return 0;
  endfunction

  // word-level model: collect W accepted pairs, then compare whole words
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      phase = 0; k = 0; a_w = '0; b_w = '0; m_equ = 1'b0; m_fd = 0;
    end else if (phase == 0) begin
      if (start) begin phase = 1; k = 0; a_w = '0; b_w = '0; end
    end else if (phase == 1) begin
      if (bit_valid) begin
        a_w[k] = a_bit;
        b_w[k] = b_bit;
        k++;
        if (k == W) begin
          phase = 2;
          m_equ = a_w == b_w;
          m_fd = lowest_diff(a_w, b_w);
        end
      end
    end else phase = 0;
  end

  initial forever begin
    @(negedge clk);
    if (chk) begin
      check("bit_ready", bit_ready, phase == 1);
      check("busy", busy, phase != 0);
      check("done", done, phase == 2);
      check("equ", equ, m_equ);
      check("first_diff", first_diff, m_fd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap_mode, input logic poke);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      int gap;
      gap = gap_mode == 1 ? (i == 2 ? 3 : 0) :
            gap_mode == 2 ? ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) : 0;
      for (int g = 0; g < gap; g++) begin
        bit_valid = 1'b0;
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
        start = poke && g == 0;
        tick();
        start = 1'b0;
      end
      bit_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      tick();
    end
    bit_valid = 1'b0;
    a_bit = 1'($urandom);
    b_bit = 1'($urandom);
    @(negedge clk);
    check("done_latency", done, 1);
    check("ready_after_last", bit_ready, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", bit_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_equ", equ, 0);
    check("rst_fd", first_diff, 0);
    tick();
    rst_n = 1'b1;
    chk = 1'b1;
    run_op(6'b101101, 6'b101101, 0, 1'b0);
    check("t1_equ", equ, 1);
    check("t1_fd", first_diff, 0);
    run_op(6'b101101, 6'b111101, 0, 1'b0);
    check("t2_equ", equ, 0);
    check("t2_fd", first_diff, 4);
    run_op(6'b000000, 6'b100001, 0, 1'b0);
    check("t3_equ", equ, 0);
    check("t3_fd", first_diff, 0);
    run_op(6'b110010, 6'b110010, 1, 1'b1);
    check("t4_equ", equ, 1);
    check("t4_fd", first_diff, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      a_bit = 1'b1;
      b_bit = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", bit_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_equ", equ, 0);
    check("mid_rst_fd", first_diff, 0);
    tick();
    rst_n = 1'b1;
    run_op(6'b011011, 6'b011011, 0, 1'b0);
    check("t5_equ", equ, 1);
    check("t5_fd", first_diff, 0);
    run_op(6'b000100, 6'b000000, 0, 1'b0);
    check("t6a_equ", equ, 0);
    check("t6a_fd", first_diff, 2);
    @(negedge clk);
    check("t6_hold_equ", equ, 0);
    check("t6_hold_fd", first_diff, 2);
    run_op(6'b111000, 6'b111000, 0, 1'b0);
    check("t6b_equ", equ, 1);
    check("t6b_fd", first_diff, 0);
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a, b;
      int sel;
      a = W'($urandom);
      sel = $urandom_range(0, 3);
      b = sel == 0 ? a : sel == 1 ? a ^ (W'(1) << $urandom_range(0, W - 1)) : W'($urandom);
      run_op(a, b, 2, 1'($urandom));
      check("rnd_equ", equ, a == b);
      check("rnd_fd", first_diff, lowest_diff(a, b));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (2) @(negedge clk);
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_equal_6.md
Name: serial_equal_6

Overview:
- Bit-serial equality checker. It receives two WIDTH-bit operands one bit pair per accepted beat, LSB first, over a valid/ready handshake.
- At the end of an operation it reports equality and the index of the lowest differing bit.
- It is the serial-input counterpart of the team's parallel 6-bit gate-level equality comparator. It sits behind a serializer or shift-register source that cannot present whole words at once.

Parameters:
- WIDTH, 6, operand width in bits; legal range 2..32.
- IDX_W (localparam), $clog2(WIDTH), width of the bit counter and of first_diff.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new comparison; sampled only in IDLE
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle
- a_bit  input  1  current bit of operand A (LSB first)
- b_bit  input  1  current bit of operand B (LSB first)
- bit_ready  output  1  block accepts a bit pair this cycle
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse: result valid
- equ  output  1  1 = operands equal; registered, held until the next done
- first_diff  output  IDX_W  index of the lowest differing bit; 0 when equ=1; held with equ

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, diff=0, bit_ready=0, busy=0, done=0, equ=0, first_diff=0.
- States: IDLE, SHIFT, DONE. Encoding is held in the shared package.
- IDLE:
  - bit_ready=0, busy=0.
  - start=1 → SHIFT next cycle; clear cnt, diff and the internal first_diff accumulator.
  - equ/first_diff keep the previous result.
- SHIFT:
  - bit_ready=1, busy=1.
  - Accept occurs on bit_valid & bit_ready.
  - On accept: if (a_bit^b_bit) and diff==0, latch first_diff_acc=cnt. Then diff |= a_bit^b_bit and cnt++.
  - Accept with cnt==WIDTH-1 → DONE next cycle; cnt wraps to 0.
  - bit_valid=0 → stall in SHIFT indefinitely; no timeout.
  - start in SHIFT is ignored; the operation is not restarted.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, bit_ready=0.
  - equ=~diff and first_diff=first_diff_acc (or 0 if equal) are registered on DONE entry, so they are visible in the same cycle as done.
  - Next state is IDLE unconditionally; start in DONE is ignored.
- Latency: done rises 1 cycle after the last accepted bit. Minimum start-to-done is WIDTH+1 cycles (start cycle, WIDTH beats, done).
- Bits are compared independently of any earlier operation; diff is fully cleared on start.
- Reset mid-operation: immediately returns to IDLE with reset values. A partial result is never reported.
- X on a_bit/b_bit when bit_valid=0 must not affect state.
- Equivalence: for any operand pair, equ equals the parallel comparator result (a==b) over WIDTH bits.

Decomposition:
- Shared package (equal_pkg):
  - state enum type (IDLE/SHIFT/DONE)
  - default WIDTH constant
  - function for IDX_W
- One natural sub-module: bit_counter_mod, a WIDTH-modulo up-counter with clear, enable and terminal-count output, reused by the team's other serial blocks.
- The mismatch accumulator and FSM stay in the top module.

Test Plan:
- Reset then start, send A=6'b101101, B=6'b101101 with bit_valid held high → done after 6 beats, equ=1, first_diff=0, bit_ready low in cycle after last beat.
- A=6'b101101, B=6'b111101 (differ at bit 4 only) → equ=0, first_diff=4.
- A=6'b000000, B=6'b100001 (differ at bits 0 and 5) → equ=0, first_diff=0; verifies lowest index wins.
- Equal operands with bit_valid gaps (valid on beats 0,1, 3 idle cycles, then 2..5) → done exactly 1 cycle after 6th accept, equ=1; start pulsed during SHIFT has no effect.
- Assert rst_n=0 after 3 accepted beats of a mismatching pair → all outputs 0, state IDLE. A new start with equal operands yields equ=1, first_diff=0.
- Back-to-back: start in the cycle after done, first pair mismatched at bit 2, second pair equal → first result equ=0/first_diff=2 held through IDLE, then replaced by equ=1/first_diff=0 at the second done.
